// File: rtl/sc_gamecontrol_fsm.sv
// Game-control FSM for Frogger: owns the lives/level counters and turns frog events into play flow.
// Optional bonus-life feature is enabled by defining SC_GAMECONTROL_BONUS_LIFE_EN.
module sc_gamecontrol_fsm #(
    parameter int LIVES_INIT = 3,
    parameter int LIVES_MAX  = 7,
    parameter int LEVELS     = 5,
    parameter int LIVES_W    = 3,
    parameter int LEVEL_W    = 3
) (
    input  logic               SC_GAMECONTROL_CLOCK_50,
    input  logic               SC_GAMECONTROL_RESET_InLow,
    input  logic               SC_GAMECONTROL_startButton_InLow,
    input  logic               SC_GAMECONTROL_Hit_InLow,
    input  logic               SC_GAMECONTROL_Goal_InLow,
    input  logic               SC_GAMECONTROL_Bonus_InLow,
    output logic [LIVES_W-1:0] SC_GAMECONTROL_Lives_Out,
    output logic [LEVEL_W-1:0] SC_GAMECONTROL_Level_Out,
    output logic               SC_GAMECONTROL_FrogReset_OutLow,
    output logic               SC_GAMECONTROL_Playing_OutHigh,
    output logic               SC_GAMECONTROL_GameOver_OutHigh,
    output logic               SC_GAMECONTROL_GameWon_OutHigh
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LOAD    = 4'd1,
        PLAY    = 4'd2,
        LOSE    = 4'd3,
        LEVEL   = 4'd4,
        BONUS   = 4'd5,
        RELEASE = 4'd6,
        OVER    = 4'd7,
        WON     = 4'd8
    } state_t;

    localparam logic [LIVES_W-1:0] LIVES_INIT_C = LIVES_W'(LIVES_INIT);
    localparam logic [LIVES_W-1:0] LIVES_MAX_C  = LIVES_W'(LIVES_MAX);
    localparam logic [LIVES_W-1:0] LIVES_ONE    = LIVES_W'(1);
    localparam logic [LEVEL_W-1:0] LEVELS_C     = LEVEL_W'(LEVELS);
    localparam logic [LEVEL_W-1:0] LEVEL_ONE    = LEVEL_W'(1);

    state_t             state_q;
    logic [LIVES_W-1:0] lives_q;
    logic [LEVEL_W-1:0] level_q;
    logic [LIVES_W-1:0] lives_inc;
    logic               bonus_evt;
    logic               events_idle;

    assign lives_inc = (lives_q < LIVES_MAX_C) ? lives_q + LIVES_ONE : lives_q;

`ifdef SC_GAMECONTROL_BONUS_LIFE_EN
    assign bonus_evt   = ~SC_GAMECONTROL_Bonus_InLow;
    assign events_idle = SC_GAMECONTROL_Hit_InLow & SC_GAMECONTROL_Goal_InLow
                       & SC_GAMECONTROL_Bonus_InLow;
`else
    logic unused_bonus;
    assign unused_bonus = SC_GAMECONTROL_Bonus_InLow;
    assign bonus_evt    = 1'b0;
    assign events_idle  = SC_GAMECONTROL_Hit_InLow & SC_GAMECONTROL_Goal_InLow;
`endif

    // NOTE: all state and counters share one clocked block with non-blocking
    // assignments, so every update in a state lands on that state's exit edge.
    always_ff @(posedge SC_GAMECONTROL_CLOCK_50 or negedge SC_GAMECONTROL_RESET_InLow) begin
        if (!SC_GAMECONTROL_RESET_InLow) begin
            state_q <= IDLE;
            lives_q <= '0;
            level_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!SC_GAMECONTROL_startButton_InLow) state_q <= LOAD;
                end
                LOAD: begin
                    lives_q <= LIVES_INIT_C;
                    level_q <= LEVEL_ONE;
                    state_q <= PLAY;
                end
                PLAY: begin
                    if (!SC_GAMECONTROL_Hit_InLow)       state_q <= LOSE;
                    else if (!SC_GAMECONTROL_Goal_InLow) state_q <= LEVEL;
                    else if (bonus_evt)                  state_q <= BONUS;
                end
                LOSE: begin
                    lives_q <= lives_q - LIVES_ONE;
                    state_q <= (lives_q == LIVES_ONE) ? OVER : RELEASE;
                end
                LEVEL: begin
                    if (level_q == LEVELS_C) begin
                        state_q <= WON;
                    end else begin
                        level_q <= level_q + LEVEL_ONE;
`ifdef SC_GAMECONTROL_BONUS_LIFE_EN
                        lives_q <= lives_inc;
`endif
                        state_q <= RELEASE;
                    end
                end
                BONUS: begin
                    lives_q <= lives_inc;
                    state_q <= RELEASE;
                end
                // Wait for every event line to go high so a held input counts once.
                RELEASE: begin
                    if (events_idle) state_q <= PLAY;
                end
                OVER, WON: begin
                    if (!SC_GAMECONTROL_startButton_InLow) state_q <= LOAD;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign SC_GAMECONTROL_Lives_Out        = lives_q;
    assign SC_GAMECONTROL_Level_Out        = level_q;
    assign SC_GAMECONTROL_FrogReset_OutLow = ~((state_q == LOAD) | (state_q == LOSE) | (state_q == LEVEL));
    assign SC_GAMECONTROL_Playing_OutHigh  = (state_q == PLAY) | (state_q == RELEASE);
    assign SC_GAMECONTROL_GameOver_OutHigh = (state_q == OVER);
    assign SC_GAMECONTROL_GameWon_OutHigh  = (state_q == WON);

endmodule

// File: tb/tb_sc_gamecontrol_fsm.sv
// Directed self-checking bench for sc_gamecontrol_fsm; expectations track SC_GAMECONTROL_BONUS_LIFE_EN.
module tb_sc_gamecontrol_fsm;

`ifdef SC_GAMECONTROL_BONUS_LIFE_EN
    localparam int BL = 1;
`else
    localparam int BL = 0;
`endif

    // Flag vector {FrogReset_OutLow, Playing, GameOver, GameWon} per state.
    localparam logic [3:0] F_IDLE  = 4'b1000;
    localparam logic [3:0] F_LOAD  = 4'b0000;
    localparam logic [3:0] F_PLAY  = 4'b1100;
    localparam logic [3:0] F_EVT   = 4'b0000;
    localparam logic [3:0] F_BONUS = 4'b1000;
    localparam logic [3:0] F_OVER  = 4'b1010;
    localparam logic [3:0] F_WON   = 4'b1001;

    logic       clk = 1'b0;
    logic       rst_n, start_n, hit_n, goal_n, bonus_n;
    logic [2:0] lives, level;
    logic       frog_n, playing, over, won;
    logic [9:0] exp_v;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    sc_gamecontrol_fsm dut (
        .SC_GAMECONTROL_CLOCK_50          (clk),
        .SC_GAMECONTROL_RESET_InLow       (rst_n),
        .SC_GAMECONTROL_startButton_InLow (start_n),
        .SC_GAMECONTROL_Hit_InLow         (hit_n),
        .SC_GAMECONTROL_Goal_InLow        (goal_n),
        .SC_GAMECONTROL_Bonus_InLow       (bonus_n),
        .SC_GAMECONTROL_Lives_Out         (lives),
        .SC_GAMECONTROL_Level_Out         (level),
        .SC_GAMECONTROL_FrogReset_OutLow  (frog_n),
        .SC_GAMECONTROL_Playing_OutHigh   (playing),
        .SC_GAMECONTROL_GameOver_OutHigh  (over),
        .SC_GAMECONTROL_GameWon_OutHigh   (won)
    );

    function automatic logic [9:0] obs();
        return {lives, level, frog_n, playing, over, won};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Reset, then start a fresh game and land in PLAY with the initial counters.
    task automatic restart();
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        start_n = 1'b0; step(); start_n = 1'b1; step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_n = 1'b1; hit_n = 1'b1; goal_n = 1'b1; bonus_n = 1'b1;
        step(); step();
        exp_v = {3'd0, 3'd0, F_IDLE}; n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL reset_state: got %b want %b", obs(), exp_v); end
        rst_n = 1'b1; step();
        exp_v = {3'd0, 3'd0, F_IDLE}; n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL idle_hold: got %b want %b", obs(), exp_v); end
    endtask

    task automatic test_start();
        start_n = 1'b0; step();
        exp_v = {3'd0, 3'd0, F_LOAD}; n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL start_load: got %b want %b", obs(), exp_v); end
        step();
        exp_v = {3'd3, 3'd1, F_PLAY}; n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL start_play: got %b want %b", obs(), exp_v); end
        step();
        exp_v = {3'd3, 3'd1, F_PLAY}; n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL start_no_retrigger: got %b want %b", obs(), exp_v); end
        start_n = 1'b1;
    endtask

    task automatic test_hits();
        for (int i = 0; i < 3; i++) begin
            hit_n = 1'b0; step();
            exp_v = {3'(3 - i), 3'd1, F_EVT}; n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL hit%0d_lose: got %b want %b", i, obs(), exp_v); end
            hit_n = 1'b1; step();
            exp_v = {3'(2 - i), 3'd1, (i == 2) ? F_OVER : F_PLAY}; n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL hit%0d_after: got %b want %b", i, obs(), exp_v); end
            step();
        end
        exp_v = {3'd0, 3'd1, F_OVER}; n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL over_hold: got %b want %b", obs(), exp_v); end
        start_n = 1'b0; step(); start_n = 1'b1; step();
        exp_v = {3'd3, 3'd1, F_PLAY}; n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL over_reload: got %b want %b", obs(), exp_v); end
    endtask

    task automatic test_goal_held();
        goal_n = 1'b0; step();
        exp_v = {3'd3, 3'd1, F_EVT}; n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL goal_level_state: got %b want %b", obs(), exp_v); end
        repeat (9) step();
        exp_v = {3'(3 + BL), 3'd2, F_PLAY}; n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL goal_held_once: got %b want %b", obs(), exp_v); end
        goal_n = 1'b1; step(); step();
        exp_v = {3'(3 + BL), 3'd2, F_PLAY}; n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL goal_release: got %b want %b", obs(), exp_v); end
    endtask

    task automatic test_hit_goal_same();
        hit_n = 1'b0; goal_n = 1'b0; step();
        hit_n = 1'b1; goal_n = 1'b1; step(); step();
        exp_v = {3'(2 + BL), 3'd2, F_PLAY}; n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL hit_goal_priority: got %b want %b", obs(), exp_v); end
    endtask

    task automatic test_win();
        restart();
        for (int i = 1; i <= 5; i++) begin
            goal_n = 1'b0; step(); goal_n = 1'b1; step();
            if (i < 5) begin
                exp_v = {3'(3 + BL * i), 3'(i + 1), F_PLAY}; n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL win_level%0d: got %b want %b", i, obs(), exp_v); end
                step();
            end
        end
        exp_v = {3'(3 + 4 * BL), 3'd5, F_WON}; n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL win_state: got %b want %b", obs(), exp_v); end
        hit_n = 1'b0; step(); hit_n = 1'b1;
        exp_v = {3'(3 + 4 * BL), 3'd5, F_WON}; n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL won_hold: got %b want %b", obs(), exp_v); end
        start_n = 1'b0; step(); start_n = 1'b1; step();
        exp_v = {3'd3, 3'd1, F_PLAY}; n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL won_reload: got %b want %b", obs(), exp_v); end
    endtask

    task automatic test_bonus();
        restart();
`ifdef SC_GAMECONTROL_BONUS_LIFE_EN
        for (int i = 0; i < 5; i++) begin
            bonus_n = 1'b0; step();
            exp_v = {3'((3 + i > 7) ? 7 : 3 + i), 3'd1, F_BONUS}; n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL bonus%0d_state: got %b want %b", i, obs(), exp_v); end
            bonus_n = 1'b1; step(); step();
        end
        exp_v = {3'd7, 3'd1, F_PLAY}; n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL bonus_saturate: got %b want %b", obs(), exp_v); end
`else
        bonus_n = 1'b0; step(); step();
        exp_v = {3'd3, 3'd1, F_PLAY}; n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL bonus_ignored: got %b want %b", obs(), exp_v); end
        bonus_n = 1'b1;
`endif
    endtask

    task automatic test_reset_midgame();
        restart();
        for (int i = 0; i < 2; i++) begin
            goal_n = 1'b0; step(); goal_n = 1'b1; step(); step();
        end
        hit_n = 1'b0; step(); hit_n = 1'b1; step(); step();
        exp_v = {3'(2 + 2 * BL), 3'd3, F_PLAY}; n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL mid_setup: got %b want %b", obs(), exp_v); end
        #2 rst_n = 1'b0; #1;
        exp_v = {3'd0, 3'd0, F_IDLE}; n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL mid_async_reset: got %b want %b", obs(), exp_v); end
        step(); rst_n = 1'b1; step();
        exp_v = {3'd0, 3'd0, F_IDLE}; n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL mid_after_reset: got %b want %b", obs(), exp_v); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_hits();
        test_goal_held();
        test_hit_goal_same();
        test_win();
        test_bonus();
        test_reset_midgame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
